// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux of 3-bit words.
// Winner is captured into a valid/ready output register.

module mux8to1 (
    input  logic [7:0][2:0] d,
    input  logic [2:0]      sel,
    output logic [2:0]      y
);

    assign y = d[sel];

endmodule

module rr_mux8_arbiter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0][W-1:0] a,
    output logic [N-1:0]        ack,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic [2:0]          out_src,
    output logic [3:0]          busy_cnt
);

    logic [2:0]   ptr;
    logic [2:0]   win;
    logic [2:0]   idx;
    logic         found;
    logic         load;
    logic [W-1:0] mux_y;

    assign load = ~out_valid | out_ready;

    // Scan requests upward from ptr; first set bit wins.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int i = 0; i < N; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // With no winner win stays at ptr, which is a harmless select.
    mux8to1 u_mux (
        .d   (a),
        .sel (win),
        .y   (mux_y)
    );

    // Grant only when the output stage can take the word.
    always_comb begin
        ack = '0;
        if (!rst && load && found) begin
            ack[win] = 1'b1;
        end
    end

    // Output stage, priority pointer and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
            busy_cnt  <= '0;
        end else begin
            if (load) begin
                if (found) begin
                    out_data  <= mux_y;
                    out_src   <= win;
                    out_valid <= 1'b1;
                    ptr       <= win + 3'd1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (out_valid && !out_ready) begin
                if (busy_cnt != 4'd15) begin
                    busy_cnt <= busy_cnt + 4'd1;
                end
            end else begin
                busy_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed bench for rr_mux8_arbiter.
// Table of per-cycle vectors plus stall and reset sequences.

module tb_rr_mux8_arbiter;

    logic             clk;
    logic             rst;
    logic [7:0]       req;
    logic [7:0][2:0]  a;
    logic [7:0]       ack;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_data;
    logic [2:0]       out_src;
    logic [3:0]       busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic            rst;
        logic [7:0]      req;
        logic [7:0][2:0] a;
        logic            rdy;
        logic [7:0]      ack;
        logic            vld;
        logic [2:0]      dat;
        logic [2:0]      src;
        logic [3:0]      bsy;
    } vec_t;

    vec_t vt[$];
    logic [7:0][2:0] ident;
    logic [7:0][2:0] first;

    rr_mux8_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] rq,
                       input logic [7:0][2:0] av, input logic rd,
                       input logic [7:0] ak, input logic v,
                       input logic [2:0] d, input logic [2:0] s,
                       input logic [3:0] b);
        vec_t x;
        x.rst = r;  x.req = rq; x.a = av; x.rdy = rd;
        x.ack = ak; x.vld = v;  x.dat = d; x.src = s; x.bsy = b;
        vt.push_back(x);
    endtask

    // Outputs sampled 1 time unit after the falling edge.
    task automatic check_all(input string tag, input logic [7:0] ak,
                             input logic v, input logic [2:0] d,
                             input logic [2:0] s, input logic [3:0] b);
        chk({tag, " ack"}, ack, ak);
        chk({tag, " valid"}, 8'(out_valid), 8'(v));
        chk({tag, " data"}, 8'(out_data), 8'(d));
        chk({tag, " src"}, 8'(out_src), 8'(s));
        chk({tag, " busy"}, 8'(busy_cnt), 8'(b));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            ident[i] = 3'(i);
            first[i] = 3'd0;
        end
        first[0] = 3'd5;

        // Each row: inputs for a cycle, outputs expected before its edge.
        add(0, 8'h01, first, 1, 8'h01, 0, 0, 0, 0);
        add(0, 8'h00, first, 1, 8'h00, 1, 5, 0, 0);
        add(1, 8'hFF, ident, 1, 8'h00, 0, 5, 0, 0);
        add(0, 8'hFF, ident, 1, 8'h01, 0, 0, 0, 0);
        add(0, 8'hFF, ident, 1, 8'h02, 1, 0, 0, 0);
        add(0, 8'hFF, ident, 1, 8'h04, 1, 1, 1, 0);
        add(0, 8'hFF, ident, 1, 8'h08, 1, 2, 2, 0);
        add(0, 8'hFF, ident, 1, 8'h10, 1, 3, 3, 0);
        add(0, 8'hFF, ident, 1, 8'h20, 1, 4, 4, 0);
        add(0, 8'hFF, ident, 1, 8'h40, 1, 5, 5, 0);
        add(0, 8'hFF, ident, 1, 8'h80, 1, 6, 6, 0);
        add(0, 8'hFF, ident, 1, 8'h01, 1, 7, 7, 0);
        add(0, 8'hFF, ident, 1, 8'h02, 1, 0, 0, 0);
        add(0, 8'h00, ident, 1, 8'h00, 1, 1, 1, 0);
        add(0, 8'h40, ident, 1, 8'h40, 0, 1, 1, 0);
        add(0, 8'h81, ident, 1, 8'h80, 1, 6, 6, 0);
        add(0, 8'h81, ident, 1, 8'h01, 1, 7, 7, 0);
        add(0, 8'h24, ident, 1, 8'h04, 1, 0, 0, 0);
        add(0, 8'h24, ident, 1, 8'h20, 1, 2, 2, 0);
        add(0, 8'h24, ident, 1, 8'h04, 1, 5, 5, 0);
        add(0, 8'h24, ident, 1, 8'h20, 1, 2, 2, 0);
        add(0, 8'h00, ident, 1, 8'h00, 1, 5, 5, 0);

        rst = 1'b1;
        req = '0;
        a = ident;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            rst = vt[i].rst;
            req = vt[i].req;
            a = vt[i].a;
            out_ready = vt[i].rdy;
            #1;
            check_all($sformatf("row%0d", i), vt[i].ack, vt[i].vld,
                      vt[i].dat, vt[i].src, vt[i].bsy);
        end

        // Stall: idle stage captures requester 4, then downstream stops.
        @(negedge clk);
        req = 8'h10;
        out_ready = 1'b0;
        #1;
        check_all("stall_load", 8'h10, 0, 5, 5, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            check_all($sformatf("stall%0d", k), 8'h00, 1, 4, 4,
                      (k > 15) ? 4'd15 : 4'(k));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_all("stall_release", 8'h10, 1, 4, 4, 15);
        @(negedge clk);
        req = 8'h00;
        out_ready = 1'b0;
        #1;
        check_all("post_release", 8'h00, 1, 4, 4, 0);

        // Reset while a word is stuck in the output stage.
        @(negedge clk);
        rst = 1'b1;
        req = 8'hFF;
        #1;
        check_all("rst_mid", 8'h00, 1, 4, 4, 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check_all("after_rst", 8'h01, 0, 0, 0, 0);
        @(negedge clk);
        req = 8'h00;
        #1;
        check_all("first_grant", 8'h00, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
